// File: rtl/muxf_arb_pkg.sv
// -----------------------------------------------------------------------------
// muxf_arb_pkg
//   Shared types and constants for the round-robin MUXF arbiter.
//     state_t  : arbiter FSM states (IDLE between packets, LOCK while an owner
//                holds the output channel).
//     SEL_W()  : width of the binary owner index for a given requester count.
//     STALL_W  : width of the optional owner-stall counter.
// -----------------------------------------------------------------------------
package muxf_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int STALL_W = 8;

    // Owner index width; clamped to 1 so a degenerate count still yields a
    // legal vector width.
    function automatic int SEL_W(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/muxf_tree.sv
// -----------------------------------------------------------------------------
// muxf_tree
//   Binary tree of 2:1 wide-function muxes selecting one requester's beat.
//   The tree nearest the leaves is the MUXF7 level, the next MUXF8, then MUXF9,
//   so NREQ = 2/4/8 uses 1/2/3 levels. Every data bit plus the packet-end flag
//   (carried as bit DW) gets its own 2:1 cell at every node.
//
//   Ports
//     data : NREQ*DW  requester i data in bits [i*DW +: DW]
//     last : NREQ     requester end-of-packet flags
//     sel  : SEL_W    binary index of the requester to pass through
//     y    : DW+1     {last[sel], data[sel]}
// -----------------------------------------------------------------------------
module muxf_tree
    import muxf_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 8,
    localparam int SW   = SEL_W(NREQ)
) (
    input  logic [NREQ*DW-1:0] data,
    input  logic [NREQ-1:0]    last,
    input  logic [SW-1:0]      sel,
    output logic [DW:0]        y
);

    localparam int DEPTH = $clog2(NREQ);

    // Heap-ordered nodes: node 0 is the root, leaves occupy NREQ-1..2*NREQ-2
    // in requester order, so the leaf path bits are exactly the binary index.
    logic [2*NREQ-2:0][DW:0] node;

    for (genvar i = 0; i < NREQ; i++) begin : g_leaf
        assign node[NREQ-1+i] = {last[i], data[i*DW +: DW]};
    end

    // Depth d counted from the root; the mux level is DEPTH-1-d, so the nodes
    // just above the leaves (MUXF7) are steered by sel[0].
    for (genvar d = 0; d < DEPTH; d++) begin : g_lvl
        for (genvar n = (1 << d) - 1; n < (2 << d) - 1; n++) begin : g_node
            for (genvar b = 0; b <= DW; b++) begin : g_bit
                assign node[n][b] = sel[DEPTH-1-d] ? node[2*n+2][b] : node[2*n+1][b];
            end
        end
    end

    assign y = node[0];

endmodule

// File: rtl/muxf_rr_arbiter.sv
// -----------------------------------------------------------------------------
// muxf_rr_arbiter
//   Round-robin, packet-locking arbiter sharing one DW-bit valid/ready/last
//   output channel among NREQ requesters. An idle arbiter spends one cycle
//   picking the next requester after the previous owner, then locks onto it
//   until its last beat is accepted. Beats pass through a MUXF7/8/9 tree into
//   a one-beat output register with full-throughput accept-while-drain.
//
//   Optional feature (macro MUXF_ARB_TIMEOUT_EN): an owner that keeps
//   REQ_VALID low for TIMEOUT_CYC consecutive locked cycles is released and
//   ERR_TIMEOUT pulses for one cycle. Without the macro the lock is held
//   indefinitely and ERR_TIMEOUT is tied low.
//
//   Ports
//     CLK, RST_N  : clock, asynchronous active-low reset
//     REQ_VALID   : NREQ     per-requester beat valid
//     REQ_LAST    : NREQ     per-requester end of packet
//     REQ_DATA    : NREQ*DW  requester i data in [i*DW +: DW]
//     REQ_READY   : NREQ     per-requester beat accept (owner only)
//     OUT_VALID   : 1        output beat valid
//     OUT_DATA    : DW       output data
//     OUT_LAST    : 1        output end of packet
//     OUT_READY   : 1        downstream accept
//     GRANT       : NREQ     one-hot owner, zero when idle
//     SEL         : SEL_W    binary owner index steering the mux tree
//     ERR_TIMEOUT : 1        one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module muxf_rr_arbiter
    import muxf_arb_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int DW          = 8,
    parameter  int TIMEOUT_CYC = 16,
    localparam int SW          = SEL_W(NREQ)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ-1:0]    REQ_LAST,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_READY,
    output logic               OUT_VALID,
    output logic [DW-1:0]      OUT_DATA,
    output logic               OUT_LAST,
    input  logic               OUT_READY,
    output logic [NREQ-1:0]    GRANT,
    output logic [SW-1:0]      SEL,
    output logic               ERR_TIMEOUT
);

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   pick;
    logic [SW-1:0]   idx;
    logic [DW:0]     tree_out;
    logic            slot_free;
    logic            accept;
    logic            drain;

    muxf_tree #(
        .NREQ (NREQ),
        .DW   (DW)
    ) u_tree (
        .data (REQ_DATA),
        .last (REQ_LAST),
        .sel  (SEL),
        .y    (tree_out)
    );

    // The output slot can take a beat when empty or when its beat leaves now.
    assign slot_free = !OUT_VALID || OUT_READY;
    assign accept    = (state == LOCK) && REQ_VALID[SEL] && slot_free;
    assign drain     = OUT_VALID && OUT_READY;

    // NOTE: every signal driven in always_comb gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        REQ_READY = '0;
        if (state == LOCK) begin
            REQ_READY[SEL] = slot_free;
        end
    end

    // Search from ptr+NREQ down to ptr+1 so the nearest valid requester after
    // the previous owner is the one left in pick. Truncation to SW bits is the
    // modulo-NREQ wrap; offset NREQ truncates to ptr itself (checked last).
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = ptr + SW'(k);
            if (REQ_VALID[idx]) begin
                pick = idx;
            end
        end
    end

`ifdef MUXF_ARB_TIMEOUT_EN
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT_CYC - 1);
    logic [STALL_W-1:0] stall_cnt;
`else
    assign ERR_TIMEOUT = 1'b0;
`endif

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            GRANT       <= '0;
            SEL         <= '0;
            ptr         <= SW'(NREQ - 1);
`ifdef MUXF_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            ERR_TIMEOUT <= 1'b0;
`endif
        end else begin
`ifdef MUXF_ARB_TIMEOUT_EN
            ERR_TIMEOUT <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef MUXF_ARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (|REQ_VALID) begin
                        GRANT <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        SEL   <= pick;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    // tree_out[DW] is the owner's REQ_LAST routed through the tree.
                    if (accept && tree_out[DW]) begin
                        ptr   <= SEL;
                        GRANT <= '0;
                        state <= IDLE;
                    end
`ifdef MUXF_ARB_TIMEOUT_EN
                    if (REQ_VALID[SEL]) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_LIM) begin
                        // Forced release; no OUT_LAST is fabricated.
                        ERR_TIMEOUT <= 1'b1;
                        stall_cnt   <= '0;
                        ptr         <= SEL;
                        GRANT       <= '0;
                        state       <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-beat output register: load on accept, clear only when the held beat
    // leaves without a replacement.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_LAST  <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= tree_out[DW-1:0];
            OUT_LAST  <= tree_out[DW];
        end else if (drain) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_LAST  <= 1'b0;
        end
    end

endmodule
